// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   rx_timer_state_t : receive bit-timer states (off, half-bit phase, running)
//   tx_timer_state_t : transmit bit-timer states (off, running)
//   UART_MIN_DIVISOR : smallest usable clocks-per-bit value
//   UART_DIV_WIDTH   : default divisor width, shared with the register block
package uart_pkg;

  localparam int unsigned UART_DIV_WIDTH   = 16;
  localparam int unsigned UART_MIN_DIVISOR = 2;

  typedef enum logic [1:0] {
    RX_OFF  = 2'd0,
    RX_HALF = 2'd1,
    RX_RUN  = 2'd2
  } rx_timer_state_t;

  typedef enum logic {
    TX_OFF = 1'b0,
    TX_RUN = 1'b1
  } tx_timer_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter producing a one-cycle registered strobe at terminal count.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : abort; holds the count and suppresses the strobe
//   load       : load load_val into the counter
//   run        : decrement; at zero, strobe and reload load_val
//   load_val   : value used by both explicit loads and terminal-count reloads
//   at_zero    : counter currently at zero (combinational, for caller state logic)
//   zero       : registered one-cycle terminal-count strobe
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = UART_DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             run,
  input  logic [WIDTH-1:0] load_val,
  output logic             at_zero,
  output logic             zero
);

  logic [WIDTH-1:0] cnt;

  assign at_zero = (cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      zero <= 1'b0;
    end else if (clr) begin
      zero <= 1'b0;
    end else if (load) begin
      cnt  <= load_val;
      zero <= 1'b0;
    end else if (run) begin
      if (at_zero) begin
        cnt  <= load_val;
        zero <= 1'b1;
      end else begin
        cnt  <= cnt - WIDTH'(1);
        zero <= 1'b0;
      end
    end else begin
      zero <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// UART bit-timing strobe generator.
//   clk, rst_n    : clock, synchronous active-low reset
//   i_divisor     : clocks per bit (values below 2 act as 2), sampled at reloads
//   i_rx_strb_en  : receiver enable; a rising edge re-phases the RX timer
//   o_rx_strb     : one-cycle mid-bit sample strobe
//   i_tx_strb_en  : transmitter enable
//   o_tx_strb     : one-cycle bit-boundary strobe
//   o_rx_busy     : RX timer active (registered status)
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = UART_DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIV_WIDTH-1:0] i_divisor,
  input  logic                 i_rx_strb_en,
  output logic                 o_rx_strb,
  input  logic                 i_tx_strb_en,
  output logic                 o_tx_strb,
  output logic                 o_rx_busy
);

  rx_timer_state_t rx_state, rx_next;
  tx_timer_state_t tx_state, tx_next;

  logic                 en_q;
  logic [DIV_WIDTH-1:0] div_eff;
  logic [DIV_WIDTH-1:0] div_m1;
  logic [DIV_WIDTH-1:0] half_m1;

  logic                 rx_load, rx_run, rx_at_zero;
  logic [DIV_WIDTH-1:0] rx_load_val;
  logic                 tx_load, tx_run, tx_at_zero;

  assign div_eff = (i_divisor < DIV_WIDTH'(UART_MIN_DIVISOR)) ? DIV_WIDTH'(UART_MIN_DIVISOR)
                                                              : i_divisor;
  assign div_m1  = div_eff - DIV_WIDTH'(1);
  assign half_m1 = (div_eff >> 1) - DIV_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state  <= RX_OFF;
      tx_state  <= TX_OFF;
      en_q      <= 1'b0;
      o_rx_busy <= 1'b0;
    end else begin
      rx_state  <= rx_next;
      tx_state  <= tx_next;
      en_q      <= i_rx_strb_en;
      o_rx_busy <= (rx_state != RX_OFF);
    end
  end

  // The RX timer shares one load_val port between the initial half-bit load
  // and the full-period reloads, so the mux follows the load request.
  always_comb begin
    rx_next     = rx_state;
    rx_load     = 1'b0;
    rx_run      = 1'b0;
    rx_load_val = div_m1;
    if (!i_rx_strb_en) begin
      rx_next = RX_OFF;
    end else begin
      unique case (rx_state)
        RX_OFF: begin
          if (!en_q) begin
            rx_load     = 1'b1;
            rx_load_val = half_m1;
            rx_next     = RX_HALF;
          end
        end
        RX_HALF: begin
          rx_run = 1'b1;
          if (rx_at_zero) rx_next = RX_RUN;
        end
        RX_RUN: begin
          rx_run = 1'b1;
        end
        default: rx_next = RX_OFF;
      endcase
    end
  end

  always_comb begin
    tx_next = tx_state;
    tx_load = 1'b0;
    tx_run  = 1'b0;
    if (!i_tx_strb_en) begin
      tx_next = TX_OFF;
    end else begin
      unique case (tx_state)
        TX_OFF: begin
          tx_load = 1'b1;
          tx_next = TX_RUN;
        end
        TX_RUN: tx_run = 1'b1;
        default: tx_next = TX_OFF;
      endcase
    end
  end

  uart_bit_timer #(.WIDTH(DIV_WIDTH)) u_rx_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (!i_rx_strb_en),
    .load     (rx_load),
    .run      (rx_run),
    .load_val (rx_load_val),
    .at_zero  (rx_at_zero),
    .zero     (o_rx_strb)
  );

  uart_bit_timer #(.WIDTH(DIV_WIDTH)) u_tx_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (!i_tx_strb_en),
    .load     (tx_load),
    .run      (tx_run),
    .load_val (div_m1),
    .at_zero  (tx_at_zero),
    .zero     (o_tx_strb)
  );

endmodule

// File: tb/tb_uart_baud_gen.sv
module tb_uart_baud_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] div = 16'd16;
  logic        rx_en = 1'b0;
  logic        tx_en = 1'b0;
  logic        o_rx_strb, o_tx_strb, o_rx_busy;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int          cyc = 0;

  // Reference model: absolute-time schedule of the next strobe per timer.
  bit m_rx_act, m_prev_en, m_rx_strb, m_busy, m_tx_act, m_tx_strb;
  int m_rx_next, m_tx_next;

  always #5 clk = ~clk;

  uart_baud_gen #(.DIV_WIDTH(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_divisor    (div),
    .i_rx_strb_en (rx_en),
    .o_rx_strb    (o_rx_strb),
    .i_tx_strb_en (tx_en),
    .o_tx_strb    (o_tx_strb),
    .o_rx_busy    (o_rx_busy)
  );

  task automatic tick();
    int d;
    @(posedge clk);
    cyc++;
    d = (div < 2) ? 2 : int'(div);
    if (!rst_n) begin
      m_rx_act = 0; m_prev_en = 0; m_rx_strb = 0; m_busy = 0;
      m_tx_act = 0; m_tx_strb = 0;
    end else begin
      m_busy    = m_rx_act;
      m_rx_strb = 0;
      if (!rx_en) m_rx_act = 0;
      else if (!m_rx_act && !m_prev_en) begin
        m_rx_act = 1; m_rx_next = cyc + d / 2;
      end else if (m_rx_act && cyc == m_rx_next) begin
        m_rx_strb = 1; m_rx_next = cyc + d;
      end
      m_prev_en = rx_en;
      m_tx_strb = 0;
      if (!tx_en) m_tx_act = 0;
      else if (!m_tx_act) begin
        m_tx_act = 1; m_tx_next = cyc + d;
      end else if (cyc == m_tx_next) begin
        m_tx_strb = 1; m_tx_next = cyc + d;
      end
    end
    #1;
  endtask

  task automatic quiesce();
    rx_en = 0; tx_en = 0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) begin
      tick();
      vectors++;
      if ({o_rx_strb, o_tx_strb, o_rx_busy} !== 3'b000) begin
        miscompares++;
        $display("FAIL reset cyc=%0d got=%b exp=000", cyc, {o_rx_strb, o_tx_strb, o_rx_busy});
      end
    end
    rst_n = 1;
    tick();
  endtask

  // Runs one RX/TX scenario: enables asserted together at offset 0, optional
  // divisor change and RX drop/re-rise, then checks every cycle against the
  // model and the first strobe offsets against fixed expectations.
  task automatic test_scenario(input string name, input int d0, input bit use_tx,
                               input int chg_at, input int d1,
                               input int drop_at, input int rise_at,
                               input int n, input int exp_rx[3], input int exp_tx[2]);
    int k;
    int rxq[$];
    int txq[$];
    quiesce();
    div = 16'(d0); rx_en = 1; tx_en = use_tx;
    tick();
    k = cyc;
    for (int i = 1; i <= n; i++) begin
      if (i == chg_at) div = 16'(d1);
      if (i == drop_at) rx_en = 0;
      if (i == rise_at) rx_en = 1;
      tick();
      vectors++;
      if ({o_rx_strb, o_tx_strb, o_rx_busy} !== {m_rx_strb, m_tx_strb, m_busy}) begin
        miscompares++;
        $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc,
                 {o_rx_strb, o_tx_strb, o_rx_busy}, {m_rx_strb, m_tx_strb, m_busy});
      end
      if (o_rx_strb) rxq.push_back(cyc - k);
      if (o_tx_strb) txq.push_back(cyc - k);
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (i >= rxq.size() || rxq[i] != exp_rx[i]) begin
        miscompares++;
        $display("FAIL %s rx_strobe%0d got=%0d exp=%0d", name, i,
                 (i < rxq.size()) ? rxq[i] : -1, exp_rx[i]);
      end
    end
    if (use_tx) begin
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (i >= txq.size() || txq[i] != exp_tx[i]) begin
          miscompares++;
          $display("FAIL %s tx_strobe%0d got=%0d exp=%0d", name, i,
                   (i < txq.size()) ? txq[i] : -1, exp_tx[i]);
        end
      end
    end
  endtask

  task automatic test_rx_basic();
    test_scenario("rx_basic", 16, 0, -1, 0, -1, -1, 45, '{8, 24, 40}, '{0, 0});
  endtask

  task automatic test_rx_odd();
    test_scenario("rx_odd", 15, 0, -1, 0, -1, -1, 40, '{7, 22, 37}, '{0, 0});
  endtask

  task automatic test_div_change();
    test_scenario("div_change", 16, 0, 10, 10, -1, -1, 40, '{8, 24, 34}, '{0, 0});
  endtask

  task automatic test_rephase();
    test_scenario("rephase", 16, 0, -1, 0, 15, 20, 50, '{8, 28, 44}, '{0, 0});
  endtask

  task automatic test_rx_tx_same();
    test_scenario("rx_tx_same", 8, 1, -1, 0, -1, -1, 24, '{4, 12, 20}, '{8, 16});
  endtask

  task automatic test_min_div();
    test_scenario("div0", 0, 1, -1, 0, -1, -1, 8, '{1, 3, 5}, '{2, 4});
    test_scenario("div1", 1, 1, -1, 0, -1, -1, 8, '{1, 3, 5}, '{2, 4});
  endtask

  task automatic test_reset_mid();
    int seen;
    quiesce();
    div = 16'd6; rx_en = 1; tx_en = 1;
    repeat (8) tick();
    rst_n = 0; rx_en = 0; tx_en = 0;
    tick();
    vectors++;
    if ({o_rx_strb, o_tx_strb, o_rx_busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_mid cyc=%0d got=%b exp=000", cyc, {o_rx_strb, o_tx_strb, o_rx_busy});
    end
    rst_n = 1;
    seen = 0;
    repeat (12) begin
      tick();
      if (o_rx_strb || o_tx_strb || o_rx_busy) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL reset_mid_idle active_cycles got=%0d exp=0", seen);
    end
    rx_en = 1; tx_en = 1;
    repeat (20) begin
      tick();
      vectors++;
      if ({o_rx_strb, o_tx_strb, o_rx_busy} !== {m_rx_strb, m_tx_strb, m_busy}) begin
        miscompares++;
        $display("FAIL reset_mid_reen cyc=%0d got=%b exp=%b", cyc,
                 {o_rx_strb, o_tx_strb, o_rx_busy}, {m_rx_strb, m_tx_strb, m_busy});
      end
    end
  endtask

  task automatic test_random();
    quiesce();
    repeat (1500) begin
      if ($urandom_range(0, 39) == 0) rx_en = ~rx_en;
      if ($urandom_range(0, 39) == 0) tx_en = ~tx_en;
      if ($urandom_range(0, 29) == 0) div = 16'($urandom_range(0, 12));
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
      vectors++;
      if ({o_rx_strb, o_tx_strb, o_rx_busy} !== {m_rx_strb, m_tx_strb, m_busy}) begin
        miscompares++;
        $display("FAIL random cyc=%0d div=%0d got=%b exp=%b", cyc, div,
                 {o_rx_strb, o_tx_strb, o_rx_busy}, {m_rx_strb, m_tx_strb, m_busy});
      end
    end
    rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_rx_basic();
    test_rx_odd();
    test_div_change();
    test_rephase();
    test_rx_tx_same();
    test_min_div();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
